// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the RV32I writeback stage.
// Holds the writeback-select and load funct3 codes, the skid FIFO entry layout and the load extractor.
package wb_stage_pkg;

   localparam int unsigned XLEN_P    = 32;
   localparam int unsigned RADDR_W_P = 5;
   localparam int unsigned DEPTH_P   = 2;

   typedef enum logic [1:0] {
      WB_SEL_ALU  = 2'b00,
      WB_SEL_LOAD = 2'b01,
      WB_SEL_PC4  = 2'b10,
      WB_SEL_RSVD = 2'b11
   } wb_sel_e;

   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101
   } load_f3_e;

   typedef struct packed {
      logic                 wr;
      logic [RADDR_W_P-1:0] rd;
      logic [XLEN_P-1:0]    data;
   } wb_item_t;

   // Byte/half selection from the low address bits; unsupported funct3 codes yield zero.
   function automatic logic [XLEN_P-1:0] load_extract(input logic [2:0] funct3,
                                                      input logic [1:0] off,
                                                      input logic [XLEN_P-1:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(word >> {off, 3'b000});
      h = off[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_LB:   load_extract = {{24{b[7]}}, b};
         F3_LBU:  load_extract = {24'h0, b};
         F3_LH:   load_extract = {{16{h[15]}}, h};
         F3_LHU:  load_extract = {16'h0, h};
         F3_LW:   load_extract = word;
         default: load_extract = '0;
      endcase
   endfunction

endpackage

// File: rtl/wb_stage_skid_fifo.sv
// Two-entry skid FIFO of writeback results, with per-entry taps for hazard comparison.
// Push is ignored when full (unless popping), pop is ignored when empty.
module wb_skid_fifo
   import wb_stage_pkg::*;
(
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              push,
   input  logic                              pop,
   input  wb_item_t                          din,
   output logic                              full,
   output logic                              empty,
   output wb_item_t                          head,
   output logic [DEPTH_P-1:0]                ent_valid,
   output logic [DEPTH_P-1:0][RADDR_W_P-1:0] ent_rd,
   output logic [DEPTH_P-1:0]                ent_wr
);

   wb_item_t   mem [DEPTH_P];
   logic       rd_ptr;
   logic       wr_ptr;
   logic [1:0] count;
   logic       do_push;
   logic       do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH_P; i++) mem[i] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   always_comb begin
      ent_valid = '0;
      ent_rd    = '0;
      ent_wr    = '0;
      for (int unsigned i = 0; i < DEPTH_P; i++) begin
         ent_valid[i] = (count == 2'd2) || (count == 2'd1 && rd_ptr == 1'(i));
         ent_rd[i]    = mem[i].rd;
         ent_wr[i]    = mem[i].wr;
      end
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: load extraction, writeback mux, 2-entry skid FIFO and registered RF write port.
// Also flags pending-write hazards for decode and counts retired instructions.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned RADDR_W = 5,
   parameter int unsigned DEPTH   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic               i_reg_wr,
   input  logic [RADDR_W-1:0] i_rd,
   input  logic [1:0]         i_wb_sel,
   input  logic [2:0]         i_funct3,
   input  logic [XLEN-1:0]    i_alu_result,
   input  logic [XLEN-1:0]    i_load_data,
   input  logic [XLEN-1:0]    i_pc,
   input  logic               i_hold,
   input  logic [RADDR_W-1:0] i_rs1,
   input  logic [RADDR_W-1:0] i_rs2,
   output logic               o_rf_wr,
   output logic [RADDR_W-1:0] o_rf_rd,
   output logic [XLEN-1:0]    o_rf_wdata,
   output logic               o_hazard,
   output logic [63:0]        o_instret
);

   wb_item_t                          new_item;
   wb_item_t                          head;
   wb_item_t                          ret_item;
   logic                              full;
   logic                              empty;
   logic                              accept;
   logic                              retire;
   logic                              push;
   logic                              pop;
   logic [DEPTH_P-1:0]                ent_valid;
   logic [DEPTH_P-1:0][RADDR_W_P-1:0] ent_rd;
   logic [DEPTH_P-1:0]                ent_wr;

   always_comb begin
      new_item    = '0;
      new_item.wr = i_reg_wr;
      new_item.rd = i_rd;
      case (wb_sel_e'(i_wb_sel))
         WB_SEL_ALU:  new_item.data = i_alu_result;
         WB_SEL_LOAD: new_item.data = load_extract(i_funct3, i_alu_result[1:0], i_load_data);
         WB_SEL_PC4:  new_item.data = i_pc + 32'd4;
         default:     new_item.data = '0;
      endcase
   end

   assign o_ready = !full;
   assign accept  = i_valid && o_ready;
   assign retire  = !i_hold && (!empty || accept);
   // An accept into an empty FIFO that retires on the same edge bypasses storage entirely.
   assign pop      = retire && !empty;
   assign push     = accept && !(retire && empty);
   assign ret_item = empty ? new_item : head;

   wb_skid_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .din       (new_item),
      .full      (full),
      .empty     (empty),
      .head      (head),
      .ent_valid (ent_valid),
      .ent_rd    (ent_rd),
      .ent_wr    (ent_wr)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_rf_wr    <= 1'b0;
         o_rf_rd    <= '0;
         o_rf_wdata <= '0;
         o_instret  <= '0;
      end else if (retire) begin
         o_rf_wr    <= ret_item.wr && (ret_item.rd != '0);
         o_rf_rd    <= ret_item.rd;
         o_rf_wdata <= ret_item.data;
         o_instret  <= o_instret + 64'd1;
      end else begin
         o_rf_wr    <= 1'b0;
      end
   end

   always_comb begin
      o_hazard = 1'b0;
      for (int unsigned i = 0; i < DEPTH_P; i++) begin
         if (ent_valid[i] && ent_wr[i] && ent_rd[i] != '0 &&
             (ent_rd[i] == i_rs1 || ent_rd[i] == i_rs2))
            o_hazard = 1'b1;
      end
      if (o_rf_wr && (o_rf_rd == i_rs1 || o_rf_rd == i_rs2))
         o_hazard = 1'b1;
   end

endmodule
